instruction_decode_unit: RTL and testbench
==========================================

Name: instruction_decode_unit

Overview:
ID stage of the 5-stage MIPS pipeline, directly downstream of instruction fetch. Contains:
- IF/ID pipeline latch with stall/flush.
- 32x32 register file with write-back port and write-through bypass.
- Immediate sign extension and main control decode.
- Load-use hazard detector that freezes PC and IF/ID and inserts a bubble.
Outputs feed the ID/EX register. branch_eq, jump and pc_write_enable return to fetch.

Parameters:
NOP_INSTRUCTION, 32'h00000000, word loaded into the latch on flush/reset.

Ports:
system_clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high
if_program_counter  in  32  PC of fetched instruction
if_instruction  in  32  fetched instruction word
stall  in  1  external hold of IF/ID
flush  in  1  squash IF/ID (taken branch/jump)
wb_reg_write  in  1  write-back enable
wb_write_reg  in  5  write-back destination
wb_write_data  in  32  write-back data
ex_mem_read  in  1  instruction in EX is a load
ex_rt  in  5  load destination in EX
id_program_counter  out  32  latched PC
id_instruction  out  32  latched instruction
id_valid  out  1  latch holds a real instruction
rs, rt, rd  out  5 each  fields [25:21], [20:16], [15:11]
read_data_1, read_data_2  out  32  register file reads of rs, rt
extended_immediate  out  32  sign-extended [15:0]
reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch_eq, jump  out  1 each  control
alu_op  out  2  00 add, 01 sub, 10 funct-decoded
hazard_stall  out  1  load-use hazard detected
pc_write_enable  out  1  fetch may advance PC

Behaviour:
- Latch update priority at posedge: reset > flush > (stall | hazard_stall) > load.
  - Reset: PC=0, instruction=NOP_INSTRUCTION, valid=0.
  - Flush: instruction=NOP_INSTRUCTION, valid=0, PC=if_program_counter.
  - Hold: all latch fields keep their values.
  - Load: latch takes if_*, valid=1.
  - Flush overrides a simultaneous hazard or stall.
- Latency: one cycle, if_* to id_*. Field, extend, regfile-read and control outputs are combinational from the latch.
- Register file:
  - Reset clears all 32 entries to 0.
  - Write at posedge when wb_reg_write=1 and wb_write_reg!=0.
  - Register 0 always reads 0.
  - Bypass: if wb_reg_write=1, wb_write_reg!=0 and wb_write_reg equals the read address, the read port returns wb_write_data in the same cycle.
- Control decode by opcode [31:26]. Any unlisted opcode gives all controls 0, alu_op=00.
  - 000000 R-type: reg_dst=1, reg_write=1, alu_op=10.
  - 100011 lw: alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1.
  - 101011 sw: alu_src=1, mem_write=1.
  - 000100 beq: branch_eq=1, alu_op=01.
  - 001000 addi: alu_src=1, reg_write=1.
  - 000010 j: jump=1.
- Bubble: when id_valid=0 or hazard_stall=1, all control outputs are forced to 0 and alu_op=00. Data and field outputs still reflect the latch.
- Hazard: hazard_stall = ex_mem_read & id_valid & (ex_rt!=0) & ((ex_rt==rs) | (ex_rt==rt & opcode in {R-type, sw, beq})). Combinational.
- pc_write_enable = !(stall | hazard_stall) | flush.
- Reset mid-stall: reset wins. After reset, hazard_stall=0 because id_valid=0.
- Write-back is unaffected by stall and flush.

Test Plan:
1. Reset for 2 cycles, then release and present PC=0x4, instr=0x8C220008 (lw $2,8($1)). Required: during reset all outputs are 0 and id_valid=0. One cycle after release: id_program_counter=0x4, mem_read=1, alu_src=1, extended_immediate=0x8, rs=1, rt=2.
2. Write $5=0xDEADBEEF via the WB port while ID holds add $3,$5,$6. Required: read_data_1=0xDEADBEEF in the same cycle (bypass). A write to $0 leaves read_data of $0 at 0.
3. Load-use: ID holds add $4,$2,$7, ex_mem_read=1, ex_rt=2. Required: hazard_stall=1, pc_write_enable=0, reg_write=0. The latch holds for the cycle; after ex_mem_read drops, add controls appear.
4. Flush and hazard in the same cycle. Required: next cycle id_valid=0, id_instruction=0, all controls 0.
5. External stall for 3 cycles while if_instruction changes. Required: id_instruction stays constant and pc_write_enable=0. After release the new word is loaded.
6. Instruction beq $1,$2,-1 (0x1022FFFF). Required: branch_eq=1, alu_op=01, extended_immediate=0xFFFFFFFF. Instruction j 0x100 gives jump=1. Opcode 0x3F gives all controls 0.

Source files
------------

// File: rtl/instruction_decode_unit_if.sv
// Bundle of the signals between fetch, write-back, EX hazard info and the
// ID stage. The ID stage uses the slave view; whatever drives the stage
// (fetch/WB/EX side or a testbench) uses the master view.
interface instruction_decode_unit_if;
  // From fetch
  logic [31:0] if_program_counter;
  logic [31:0] if_instruction;
  logic        stall;
  logic        flush;
  // From write-back
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  // From EX, for load-use detection
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  // Towards ID/EX and back to fetch
  logic [31:0] id_program_counter;
  logic [31:0] id_instruction;
  logic        id_valid;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [31:0] extended_immediate;
  logic        reg_dst;
  logic        alu_src;
  logic        mem_to_reg;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch_eq;
  logic        jump;
  logic [1:0]  alu_op;
  logic        hazard_stall;
  logic        pc_write_enable;

  modport master (
    output if_program_counter, if_instruction, stall, flush,
           wb_reg_write, wb_write_reg, wb_write_data, ex_mem_read, ex_rt,
    input  id_program_counter, id_instruction, id_valid, rs, rt, rd,
           read_data_1, read_data_2, extended_immediate, reg_dst, alu_src,
           mem_to_reg, reg_write, mem_read, mem_write, branch_eq, jump,
           alu_op, hazard_stall, pc_write_enable
  );

  modport slave (
    input  if_program_counter, if_instruction, stall, flush,
           wb_reg_write, wb_write_reg, wb_write_data, ex_mem_read, ex_rt,
    output id_program_counter, id_instruction, id_valid, rs, rt, rd,
           read_data_1, read_data_2, extended_immediate, reg_dst, alu_src,
           mem_to_reg, reg_write, mem_read, mem_write, branch_eq, jump,
           alu_op, hazard_stall, pc_write_enable
  );
endinterface

// File: rtl/instruction_decode_unit.sv
// MIPS ID stage: IF/ID latch with stall/flush, 32x32 register file with
// write-through bypass, sign extension, main control decode and load-use
// hazard detection. All decode outputs are combinational from the latch.
module instruction_decode_unit #(
  parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0000
) (
  input logic                     system_clock,
  input logic                     reset,
  instruction_decode_unit_if.slave bus
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch_eq;
    logic    jump;
    alu_op_e alu_op;
  } ctrl_t;

  // IF/ID latch
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;

  // Register file; entry 0 is never written and always reads as zero
  logic [31:0] regs_q [32];

  logic [5:0]  opcode_bits;
  opcode_e     opcode;
  logic [4:0]  rs, rt, rd;
  logic        rt_is_source;
  logic        hazard_stall;
  logic        wb_active;
  ctrl_t       ctrl_raw;
  ctrl_t       ctrl;

  assign opcode_bits = id_instr_q[31:26];
  assign opcode      = opcode_e'(opcode_bits);
  assign rs          = id_instr_q[25:21];
  assign rt          = id_instr_q[20:16];
  assign rd          = id_instr_q[15:11];

  // A write-back to $0 is discarded, so it must neither write nor bypass.
  assign wb_active = bus.wb_reg_write && (bus.wb_write_reg != 5'd0);

  // Only R-type, sw and beq read rt as a source; lw/addi write it instead.
  assign rt_is_source = (opcode == OP_RTYPE) || (opcode == OP_SW) ||
                        (opcode == OP_BEQ);

  assign hazard_stall = bus.ex_mem_read && id_valid_q && (bus.ex_rt != 5'd0) &&
                        ((bus.ex_rt == rs) || ((bus.ex_rt == rt) && rt_is_source));

  // Next-state of the IF/ID latch: flush beats any hold, hold beats load
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    if (bus.flush) begin
      id_pc_d    = bus.if_program_counter;
      id_instr_d = NOP_INSTRUCTION;
      id_valid_d = 1'b0;
    end else if (!(bus.stall || hazard_stall)) begin
      id_pc_d    = bus.if_program_counter;
      id_instr_d = bus.if_instruction;
      id_valid_d = 1'b1;
    end
  end

  // IF/ID latch register with synchronous reset
  always_ff @(posedge system_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      id_pc_q    <= 32'h0000_0000;
      id_instr_q <= NOP_INSTRUCTION;
      id_valid_q <= 1'b0;
    end else begin
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
    end
  end

  // Register file write port; write-back ignores stall and flush
  always_ff @(posedge system_clock) begin
    // NOTE: this array is reset on purpose so the architected registers start
    // at zero; that keeps it in flops rather than a RAM macro.
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0000_0000;
    end else if (wb_active) begin
      regs_q[bus.wb_write_reg] <= bus.wb_write_data;
    end
  end

  // Read with $0 forced to zero and same-cycle write-through
  function automatic logic [31:0] read_reg(input logic [4:0] addr);
    if (addr == 5'd0)                          return 32'h0000_0000;
    else if (wb_active && bus.wb_write_reg == addr) return bus.wb_write_data;
    else                                       return regs_q[addr];
  endfunction

  // Main control decode from the opcode of the latched instruction
  always_comb begin
    ctrl_raw = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl_raw.reg_dst   = 1'b1;
        ctrl_raw.reg_write = 1'b1;
        ctrl_raw.alu_op    = ALU_FUNCT;
      end
      OP_LW: begin
        ctrl_raw.alu_src    = 1'b1;
        ctrl_raw.mem_to_reg = 1'b1;
        ctrl_raw.reg_write  = 1'b1;
        ctrl_raw.mem_read   = 1'b1;
      end
      OP_SW: begin
        ctrl_raw.alu_src   = 1'b1;
        ctrl_raw.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl_raw.branch_eq = 1'b1;
        ctrl_raw.alu_op    = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl_raw.alu_src   = 1'b1;
        ctrl_raw.reg_write = 1'b1;
      end
      OP_J: begin
        ctrl_raw.jump = 1'b1;
      end
      default: ctrl_raw = '0;
    endcase
  end

  // An empty latch or a detected hazard sends a bubble down the pipe.
  assign ctrl = (id_valid_q && !hazard_stall) ? ctrl_raw : '0;

  assign bus.id_program_counter = id_pc_q;
  assign bus.id_instruction     = id_instr_q;
  assign bus.id_valid           = id_valid_q;
  assign bus.rs                 = rs;
  assign bus.rt                 = rt;
  assign bus.rd                 = rd;
  assign bus.read_data_1        = read_reg(rs);
  assign bus.read_data_2        = read_reg(rt);
  assign bus.extended_immediate = {{16{id_instr_q[15]}}, id_instr_q[15:0]};
  assign bus.reg_dst            = ctrl.reg_dst;
  assign bus.alu_src            = ctrl.alu_src;
  assign bus.mem_to_reg         = ctrl.mem_to_reg;
  assign bus.reg_write          = ctrl.reg_write;
  assign bus.mem_read           = ctrl.mem_read;
  assign bus.mem_write          = ctrl.mem_write;
  assign bus.branch_eq          = ctrl.branch_eq;
  assign bus.jump               = ctrl.jump;
  assign bus.alu_op             = ctrl.alu_op;
  assign bus.hazard_stall       = hazard_stall;
  assign bus.pc_write_enable    = !(bus.stall || hazard_stall) || bus.flush;

endmodule

// File: tb/tb_instruction_decode_unit.sv
// Scoreboard bench for the ID stage. The stimulus process drives inputs just
// after each rising edge and queues the values expected at the following
// falling edge; the monitor drains the queue at every falling edge.
module tb_instruction_decode_unit;

  typedef enum int {
    F_PC, F_INSTR, F_VALID, F_RS, F_RT, F_RD, F_RD1, F_RD2, F_IMM,
    F_CTRL, F_HAZARD, F_PCWE
  } field_e;

  typedef struct {
    field_e      field;
    logic [31:0] value;
    string       name;
  } exp_t;

  // Control vector: {reg_dst, alu_src, mem_to_reg, reg_write, mem_read,
  //                  mem_write, branch_eq, jump, alu_op[1:0]}
  localparam logic [31:0] C_NONE = 32'b00_0000_0000;
  localparam logic [31:0] C_R    = 32'b10_0100_0010;
  localparam logic [31:0] C_LW   = 32'b01_1110_0000;
  localparam logic [31:0] C_SW   = 32'b01_0001_0000;
  localparam logic [31:0] C_BEQ  = 32'b00_0000_1001;
  localparam logic [31:0] C_ADDI = 32'b01_0100_0000;
  localparam logic [31:0] C_J    = 32'b00_0000_0100;

  localparam logic [31:0] I_LW   = 32'h8C22_0008; // lw   $2,8($1)
  localparam logic [31:0] I_ADD5 = 32'h00A0_1820; // add  $3,$5,$0
  localparam logic [31:0] I_ADD2 = 32'h0047_2020; // add  $4,$2,$7
  localparam logic [31:0] I_ADDI = 32'h2001_0005; // addi $1,$0,5
  localparam logic [31:0] I_SW   = 32'hAC62_0004; // sw   $2,4($3)
  localparam logic [31:0] I_BEQ  = 32'h1022_FFFF; // beq  $1,$2,-1
  localparam logic [31:0] I_J    = 32'h0800_0100; // j    0x100
  localparam logic [31:0] I_BAD  = 32'hFC00_0000; // opcode 0x3F

  logic clk;
  logic reset;
  int   n_compared;
  int   n_mismatched;
  exp_t sb_q[$];

  instruction_decode_unit_if bus ();

  instruction_decode_unit #(.NOP_INSTRUCTION(32'h0000_0000)) dut (
    .system_clock (clk),
    .reset        (reset),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] actual_of(input field_e f);
    case (f)
      F_PC:     return bus.id_program_counter;
      F_INSTR:  return bus.id_instruction;
      F_VALID:  return {31'd0, bus.id_valid};
      F_RS:     return {27'd0, bus.rs};
      F_RT:     return {27'd0, bus.rt};
      F_RD:     return {27'd0, bus.rd};
      F_RD1:    return bus.read_data_1;
      F_RD2:    return bus.read_data_2;
      F_IMM:    return bus.extended_immediate;
      F_CTRL:   return {22'd0, bus.reg_dst, bus.alu_src, bus.mem_to_reg,
                        bus.reg_write, bus.mem_read, bus.mem_write,
                        bus.branch_eq, bus.jump, bus.alu_op};
      F_HAZARD: return {31'd0, bus.hazard_stall};
      F_PCWE:   return {31'd0, bus.pc_write_enable};
      default:  return 32'hXXXX_XXXX;
    endcase
  endfunction

  // Monitor: compare every expectation queued for this falling edge
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check(e.name, actual_of(e.field), e.value);
    end
  end

  task automatic push_exp(input field_e f, input logic [31:0] v, input string name);
    exp_t e;
    e.field = f;
    e.value = v;
    e.name  = name;
    sb_q.push_back(e);
  endtask

  task automatic slot();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
    bus.if_program_counter = pc;
    bus.if_instruction     = instr;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset = 1'b1;
    bus.stall = 1'b0;         bus.flush = 1'b0;
    bus.wb_reg_write = 1'b0;  bus.wb_write_reg = 5'd0; bus.wb_write_data = '0;
    bus.ex_mem_read = 1'b0;   bus.ex_rt = 5'd0;
    fetch(32'h4, I_LW);

    // Reset, two cycles
    for (int i = 0; i < 2; i++) begin
      slot();
      push_exp(F_VALID, 0, "rst_valid");
      push_exp(F_PC, 0, "rst_pc");
      push_exp(F_INSTR, 0, "rst_instr");
      push_exp(F_CTRL, C_NONE, "rst_ctrl");
      push_exp(F_RD1, 0, "rst_rd1");
      push_exp(F_IMM, 0, "rst_imm");
      push_exp(F_HAZARD, 0, "rst_hazard");
    end
    reset = 1'b0;

    // lw loaded one cycle after release
    slot();
    push_exp(F_PC, 32'h4, "lw_pc");
    push_exp(F_VALID, 1, "lw_valid");
    push_exp(F_CTRL, C_LW, "lw_ctrl");
    push_exp(F_IMM, 32'h8, "lw_imm");
    push_exp(F_RS, 1, "lw_rs");
    push_exp(F_RT, 2, "lw_rt");
    fetch(32'h8, I_ADD5);

    // Write $5 while ID holds add $3,$5,$0: bypass
    slot();
    bus.wb_reg_write = 1'b1; bus.wb_write_reg = 5'd5; bus.wb_write_data = 32'hDEADBEEF;
    push_exp(F_RD1, 32'hDEADBEEF, "bypass_rd1");
    push_exp(F_RD2, 0, "bypass_rd2");
    push_exp(F_RD, 3, "add_rd");
    push_exp(F_CTRL, C_R, "add_ctrl");

    // Stored $5 visible; a write to $0 must not bypass
    slot();
    bus.wb_write_reg = 5'd0; bus.wb_write_data = 32'h12345678;
    push_exp(F_RD1, 32'hDEADBEEF, "stored_rd1");
    push_exp(F_RD2, 0, "zero_bypass_rd2");
    fetch(32'h10, I_ADD2);

    // Load-use on rs: hazard, bubble, PC frozen
    slot();
    bus.wb_reg_write = 1'b0;
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd2;
    fetch(32'h14, I_ADDI);
    push_exp(F_INSTR, I_ADD2, "hz_instr");
    push_exp(F_HAZARD, 1, "hz_stall");
    push_exp(F_PCWE, 0, "hz_pcwe");
    push_exp(F_CTRL, C_NONE, "hz_ctrl");

    // Latch held; load gone, add controls appear
    slot();
    bus.ex_mem_read = 1'b0;
    push_exp(F_INSTR, I_ADD2, "hz_hold_instr");
    push_exp(F_PC, 32'h10, "hz_hold_pc");
    push_exp(F_HAZARD, 0, "hz_clear");
    push_exp(F_CTRL, C_R, "hz_after_ctrl");
    push_exp(F_PCWE, 1, "hz_after_pcwe");

    // addi: rt is a destination, so ex_rt==rt is no hazard
    slot();
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd1;
    fetch(32'h18, I_SW);
    push_exp(F_INSTR, I_ADDI, "addi_instr");
    push_exp(F_CTRL, C_ADDI, "addi_ctrl");
    push_exp(F_IMM, 32'h5, "addi_imm");
    push_exp(F_HAZARD, 0, "addi_no_hazard");

    // sw rt hazard together with flush
    slot();
    bus.ex_rt = 5'd2; bus.flush = 1'b1;
    fetch(32'h1C, I_LW);
    push_exp(F_INSTR, I_SW, "sw_instr");
    push_exp(F_HAZARD, 1, "sw_rt_hazard");
    push_exp(F_PCWE, 1, "flush_pcwe");
    push_exp(F_CTRL, C_NONE, "sw_bubble_ctrl");

    // Flush won over hazard
    slot();
    bus.flush = 1'b0; bus.ex_mem_read = 1'b0;
    fetch(32'h20, I_ADD5);
    push_exp(F_VALID, 0, "flush_valid");
    push_exp(F_INSTR, 0, "flush_instr");
    push_exp(F_PC, 32'h1C, "flush_pc");
    push_exp(F_CTRL, C_NONE, "flush_ctrl");
    push_exp(F_RD1, 0, "r0_rd1");
    push_exp(F_RD2, 0, "r0_rd2");

    // External stall for three cycles
    slot();
    bus.stall = 1'b1;
    fetch(32'h24, I_LW);
    push_exp(F_INSTR, I_ADD5, "stall1_instr");
    push_exp(F_PCWE, 0, "stall1_pcwe");
    push_exp(F_RD1, 32'hDEADBEEF, "stall1_rd1");
    slot();
    fetch(32'h28, I_SW);
    push_exp(F_INSTR, I_ADD5, "stall2_instr");
    push_exp(F_PC, 32'h20, "stall2_pc");
    push_exp(F_PCWE, 0, "stall2_pcwe");
    slot();
    fetch(32'h2C, I_BEQ);
    push_exp(F_INSTR, I_ADD5, "stall3_instr");
    push_exp(F_PCWE, 0, "stall3_pcwe");
    slot();
    bus.stall = 1'b0;
    push_exp(F_INSTR, I_ADD5, "stall_end_instr");
    push_exp(F_PCWE, 1, "stall_end_pcwe");

    // beq, j, unknown opcode
    slot();
    fetch(32'h30, I_J);
    push_exp(F_INSTR, I_BEQ, "beq_instr");
    push_exp(F_PC, 32'h2C, "beq_pc");
    push_exp(F_CTRL, C_BEQ, "beq_ctrl");
    push_exp(F_IMM, 32'hFFFFFFFF, "beq_imm");
    slot();
    fetch(32'h34, I_BAD);
    push_exp(F_CTRL, C_J, "j_ctrl");
    slot();
    push_exp(F_VALID, 1, "bad_valid");
    push_exp(F_CTRL, C_NONE, "bad_ctrl");

    // Reset during stall with a pending load in EX
    bus.stall = 1'b1; reset = 1'b1;
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd5;
    slot();
    push_exp(F_VALID, 0, "rst2_valid");
    push_exp(F_PC, 0, "rst2_pc");
    push_exp(F_INSTR, 0, "rst2_instr");
    push_exp(F_HAZARD, 0, "rst2_hazard");
    push_exp(F_CTRL, C_NONE, "rst2_ctrl");
    reset = 1'b0; bus.stall = 1'b0; bus.ex_mem_read = 1'b0;
    fetch(32'h40, I_ADD5);

    // Register file was cleared by the reset
    slot();
    push_exp(F_INSTR, I_ADD5, "post_rst_instr");
    push_exp(F_RD1, 0, "post_rst_rd1");
    push_exp(F_CTRL, C_R, "post_rst_ctrl");

    slot();
    check("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
